// File: rtl/stage_mem.sv
// Memory stage: issues data loads/stores over a req/ack bus, stalls upstream while
// an access is outstanding, and registers the extended writeback bundle for WB.
module stage_mem #(
    parameter int unsigned BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       memOp_in,
    input  logic [5:0]       wdOp_in,
    input  logic [BUS_W-1:0] rs2Data_in,
    input  logic [BUS_W-1:0] exResult_in,
    output logic             stall_out,
    output logic             dReq_out,
    output logic             dWe_out,
    output logic [BUS_W-1:0] dAddr_out,
    output logic [BUS_W-1:0] dWdata_out,
    output logic [3:0]       dBe_out,
    input  logic [BUS_W-1:0] dRdata_in,
    input  logic             dAck_in,
    output logic [5:0]       wdOp_out,
    output logic [BUS_W-1:0] wbData_out,
    output logic             misalign_out
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e           state_q, state_d;
    logic             dreq_q, dreq_d, dwe_q, dwe_d, misalign_q, misalign_d;
    logic [BUS_W-1:0] daddr_q, daddr_d, dwdata_q, dwdata_d, wbdata_q, wbdata_d;
    logic [BUS_W-1:0] hold_q, hold_d;
    logic [3:0]       dbe_q, dbe_d;
    logic [5:0]       wdop_q, wdop_d, lat_wdop_q, lat_wdop_d;
    logic [1:0]       lat_size_q, lat_size_d, lat_off_q, lat_off_d;
    logic             lat_uns_q, lat_uns_d, lat_we_q, lat_we_d;

    logic             mem_en, is_half, is_word, misaligned, access;
    logic [1:0]       off;
    logic [3:0]       be_mask;
    logic [BUS_W-1:0] st_data, shifted, ld_ext;

    assign mem_en     = memOp_in[0];
    assign is_half    = (memOp_in[3:2] == 2'b01);
    assign is_word    = memOp_in[3];
    assign off        = exResult_in[1:0];
    assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
    assign access     = mem_en & ~misaligned;

    always_comb begin
        be_mask = 4'b1111;
        st_data = rs2Data_in;
        if (memOp_in[3:2] == 2'b00) begin
            be_mask = 4'b0001 << off;
            st_data = {4{rs2Data_in[7:0]}};
        end else if (is_half) begin
            be_mask = 4'b0011 << off;
            st_data = {2{rs2Data_in[15:0]}};
        end
    end

    // Load extraction works from the held read data and the latched access shape.
    assign shifted = hold_q >> {lat_off_q, 3'b000};
    always_comb begin
        ld_ext = shifted;
        if (lat_size_q == 2'b00) begin
            ld_ext = {{24{shifted[7] & ~lat_uns_q}}, shifted[7:0]};
        end else if (lat_size_q == 2'b01) begin
            ld_ext = {{16{shifted[15] & ~lat_uns_q}}, shifted[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        dreq_d     = dreq_q;
        dwe_d      = dwe_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        dbe_d      = dbe_q;
        wdop_d     = wdop_q;
        wbdata_d   = wbdata_q;
        misalign_d = 1'b0;
        hold_d     = hold_q;
        lat_wdop_d = lat_wdop_q;
        lat_size_d = lat_size_q;
        lat_off_d  = lat_off_q;
        lat_uns_d  = lat_uns_q;
        lat_we_d   = lat_we_q;
        stall_out  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!mem_en) begin
                    wdop_d   = wdOp_in;
                    wbdata_d = exResult_in;
                end else if (misaligned) begin
                    misalign_d = 1'b1;
                    wdop_d     = '0;
                end else begin
                    stall_out  = 1'b1;
                    dreq_d     = 1'b1;
                    dwe_d      = memOp_in[1];
                    daddr_d    = exResult_in;
                    dwdata_d   = st_data;
                    dbe_d      = be_mask;
                    lat_wdop_d = wdOp_in;
                    lat_size_d = memOp_in[3:2];
                    lat_uns_d  = memOp_in[4];
                    lat_off_d  = off;
                    lat_we_d   = memOp_in[1];
                    wdop_d     = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                stall_out = 1'b1;
                wdop_d    = '0;
                if (dAck_in) begin
                    dreq_d  = 1'b0;
                    hold_d  = dRdata_in;
                    state_d = StDone;
                end
            end
            StDone: begin
                wdop_d   = lat_wdop_q;
                wbdata_d = lat_we_q ? '0 : ld_ext;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Keep stall low while reset is held, whatever the input bundle looks like.
        if (!rst) stall_out = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            dreq_q     <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            dbe_q      <= '0;
            wdop_q     <= '0;
            wbdata_q   <= '0;
            misalign_q <= 1'b0;
            hold_q     <= '0;
            lat_wdop_q <= '0;
            lat_size_q <= '0;
            lat_off_q  <= '0;
            lat_uns_q  <= 1'b0;
            lat_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dreq_q     <= dreq_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            dbe_q      <= dbe_d;
            wdop_q     <= wdop_d;
            wbdata_q   <= wbdata_d;
            misalign_q <= misalign_d;
            hold_q     <= hold_d;
            lat_wdop_q <= lat_wdop_d;
            lat_size_q <= lat_size_d;
            lat_off_q  <= lat_off_d;
            lat_uns_q  <= lat_uns_d;
            lat_we_q   <= lat_we_d;
        end
    end

    assign dReq_out     = dreq_q;
    assign dWe_out      = dwe_q;
    assign dAddr_out    = daddr_q;
    assign dWdata_out   = dwdata_q;
    assign dBe_out      = dbe_q;
    assign wdOp_out     = wdop_q;
    assign wbData_out   = wbdata_q;
    assign misalign_out = misalign_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed test-plan cases plus random ops against a
// byte-arithmetic reference of the load/store lane rules.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  memOp_in;
    logic [5:0]  wdOp_in;
    logic [31:0] rs2Data_in, exResult_in, dRdata_in;
    logic        dAck_in;
    logic        stall_out, dReq_out, dWe_out, misalign_out;
    logic [31:0] dAddr_out, dWdata_out, wbData_out;
    logic [3:0]  dBe_out;
    logic [5:0]  wdOp_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_mem #(.BUS_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .memOp_in     (memOp_in),
        .wdOp_in      (wdOp_in),
        .rs2Data_in   (rs2Data_in),
        .exResult_in  (exResult_in),
        .stall_out    (stall_out),
        .dReq_out     (dReq_out),
        .dWe_out      (dWe_out),
        .dAddr_out    (dAddr_out),
        .dWdata_out   (dWdata_out),
        .dBe_out      (dBe_out),
        .dRdata_in    (dRdata_in),
        .dAck_in      (dAck_in),
        .wdOp_out     (wdOp_out),
        .wbData_out   (wbData_out),
        .misalign_out (misalign_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through the stage and checks every cycle of it.
    task automatic do_op(input logic [4:0] mop, input logic [5:0] wd, input logic [31:0] rs2,
                         input logic [31:0] addr, input int ack_delay,
                         input logic [31:0] rdata);
        int          nbytes, offs;
        bit          en, wr, uns, mis;
        logic [31:0] e_mask, e_wdata, e_wb, ones;
        longint unsigned f;
        en     = mop[0];
        wr     = mop[1];
        uns    = mop[4];
        nbytes = (mop[3:2] == 2'b00) ? 1 : (mop[3:2] == 2'b01) ? 2 : 4;
        offs   = int'(addr % 4);
        mis    = en && ((addr % nbytes) != 0);
        e_mask = ((32'd1 << nbytes) - 1) << offs;
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = rs2[8*(i % nbytes) +: 8];
        f = (longint'(rdata) >> (8 * offs)) & ((64'd1 << (8 * nbytes)) - 1);
        e_wb = f[31:0];
        ones = '1;
        if (!uns && nbytes < 4 && f >= (64'd1 << (8 * nbytes - 1))) e_wb = e_wb | (ones << (8 * nbytes));
        if (wr) e_wb = 32'h0;

        memOp_in = mop; wdOp_in = wd; rs2Data_in = rs2; exResult_in = addr;
        dRdata_in = 32'h0; dAck_in = 1'b0;
        #1;
        if (!en) begin
            check("nop_stall", {31'h0, stall_out}, 32'h0);
            step();
            check("nop_wdop", {26'h0, wdOp_out}, {26'h0, wd});
            check("nop_wb", wbData_out, addr);
            check("nop_req", {31'h0, dReq_out}, 32'h0);
            check("nop_mis", {31'h0, misalign_out}, 32'h0);
        end else if (mis) begin
            check("mis_stall", {31'h0, stall_out}, 32'h0);
            step();
            check("mis_pulse", {31'h0, misalign_out}, 32'h1);
            check("mis_req", {31'h0, dReq_out}, 32'h0);
            check("mis_wdop", {26'h0, wdOp_out}, 32'h0);
            check("mis_stall2", {31'h0, stall_out}, 32'h0);
        end else begin
            check("acc_stall0", {31'h0, stall_out}, 32'h1);
            step();
            for (int c = 0; c <= ack_delay; c++) begin
                check("req_req", {31'h0, dReq_out}, 32'h1);
                check("req_we", {31'h0, dWe_out}, {31'h0, wr});
                check("req_addr", dAddr_out, addr);
                check("req_be", {28'h0, dBe_out}, e_mask);
                if (wr) check("req_wdata", dWdata_out, e_wdata);
                check("req_stall", {31'h0, stall_out}, 32'h1);
                check("req_wdop", {26'h0, wdOp_out}, 32'h0);
                if (c == ack_delay) begin
                    dAck_in = 1'b1; dRdata_in = rdata;
                end
                step();
            end
            dAck_in = 1'b0; dRdata_in = 32'h0;
            check("done_req", {31'h0, dReq_out}, 32'h0);
            check("done_stall", {31'h0, stall_out}, 32'h0);
            step();
            check("wb_wdop", {26'h0, wdOp_out}, {26'h0, wd});
            check("wb_data", wbData_out, e_wb);
        end
    endtask

    initial begin
        rst = 1'b0;
        memOp_in = '0; wdOp_in = '0; rs2Data_in = '0; exResult_in = '0;
        dRdata_in = '0; dAck_in = 1'b0;
        #12;
        check("rst_stall", {31'h0, stall_out}, 32'h0);
        check("rst_req", {31'h0, dReq_out}, 32'h0);
        check("rst_wdop", {26'h0, wdOp_out}, 32'h0);
        check("rst_wb", wbData_out, 32'h0);
        check("rst_mis", {31'h0, misalign_out}, 32'h0);
        check("rst_addr", dAddr_out, 32'h0);
        rst = 1'b1;
        step();

        do_op(5'h00, 6'b001011, 32'h0, 32'h1234, 0, 32'h0);
        do_op(5'b00001, 6'b000101, 32'h0, 32'h103, 1, 32'h80FF_0000);
        do_op(5'b10101, 6'b000111, 32'h0, 32'h202, 0, 32'hBEEF_1234);
        do_op(5'b00101, 6'b001001, 32'h0, 32'h202, 2, 32'hBEEF_1234);
        do_op(5'b00011, 6'b000000, 32'hAABB_CCDD, 32'h301, 10, 32'h0);
        do_op(5'b01001, 6'b010001, 32'h0, 32'h402, 0, 32'h0);
        do_op(5'h00, 6'b100001, 32'h0, 32'hCAFE_0001, 0, 32'h0);

        // Reset while a request is outstanding.
        memOp_in = 5'b01001; wdOp_in = 6'b000011; exResult_in = 32'h500;
        step();
        check("rr_req", {31'h0, dReq_out}, 32'h1);
        rst = 1'b0;
        #1;
        check("rr_req_drop", {31'h0, dReq_out}, 32'h0);
        check("rr_stall", {31'h0, stall_out}, 32'h0);
        memOp_in = 5'h00;
        step();
        rst = 1'b1;
        dAck_in = 1'b1; dRdata_in = 32'hDEAD_BEEF;
        memOp_in = 5'h00; wdOp_in = 6'b000101; exResult_in = 32'h7777;
        step();
        check("rr_stray_req", {31'h0, dReq_out}, 32'h0);
        check("rr_pass_wb", wbData_out, 32'h7777);
        check("rr_pass_wdop", {26'h0, wdOp_out}, 32'h5);
        dAck_in = 1'b0;

        for (int k = 0; k < 60; k++) begin
            do_op(5'($urandom), 6'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
                  $urandom);
        end
        memOp_in = 5'h00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Consumer end of the execute-stage output bundle (memOp, wdOp, rs2Data, exResult) in the RV pipeline.
- Decodes memOp and performs data-memory loads and stores over a req/ack bus, stalling upstream while an access is outstanding.
- Sign- or zero-extends load data and registers the writeback bundle for the WB stage.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- BUS_W, 32, datapath width. Byte-lane logic is defined for 32 only.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- memOp_in  input  5  [0] memEn, [1] write (1=store), [3:2] size (00 byte, 01 half, 10 word, 11 treated as word), [4] unsigned load
- wdOp_in  input  6  writeback op: [0] rd write enable, [5:1] rd index; passed through
- rs2Data_in  input  BUS_W  store data
- exResult_in  input  BUS_W  effective address, or ALU result for non-memory ops
- stall_out  output  1  combinational; upstream holds its registers while 1
- dReq_out  output  1  bus request, registered
- dWe_out  output  1  bus write enable, registered
- dAddr_out  output  BUS_W  byte address, registered
- dWdata_out  output  BUS_W  lane-replicated store data, registered
- dBe_out  output  4  byte enables, registered
- dRdata_in  input  BUS_W  load data, valid when dAck_in=1
- dAck_in  input  1  bus completion, single-cycle pulse
- wdOp_out  output  6  registered writeback op
- wbData_out  output  BUS_W  registered writeback data
- misalign_out  output  1  registered 1-cycle pulse on a misaligned access

Behaviour:
- Reset values: state IDLE; all outputs 0, including dReq_out and stall_out.
- Alignment: misaligned = (half and addr[0]) or (word and addr[1:0]!=0).
- Access = memEn and not misaligned.
- States: IDLE, REQ, DONE.
- IDLE, no memEn:
  - wdOp_out <= wdOp_in; wbData_out <= exResult_in.
  - stall_out = 0; latency 1 cycle.
- IDLE, memEn and misaligned:
  - No bus request; misalign_out <= 1 for one cycle; wdOp_out <= 0.
  - stall_out = 0; stay IDLE.
- IDLE, access:
  - stall_out = 1 combinationally.
  - Register dReq_out <= 1, dWe_out, dAddr_out = exResult_in, dWdata_out, dBe_out.
  - Latch wdOp, size, unsigned flag and addr[1:0].
  - wdOp_out <= 0 (bubble); go to REQ.
- REQ:
  - stall_out = 1; wdOp_out <= 0.
  - Bus outputs held stable until ack.
  - On dAck_in: dReq_out <= 0; capture dRdata_in into an internal holding register; go to DONE.
  - Without ack: stay in REQ indefinitely.
- DONE:
  - stall_out = 0.
  - wdOp_out <= latched wdOp.
  - wbData_out <= extended load data, or 0 for a store.
  - Go to IDLE. The instruction at the input during DONE is the consumed one and is not re-issued; the new instruction arrives the next cycle.
- Store lanes:
  - Byte: Wdata = {4{rs2[7:0]}}, Be = 0001 << addr[1:0].
  - Half: Wdata = {2{rs2[15:0]}}, Be = 0011 << addr[1:0].
  - Word: Wdata = rs2, Be = 1111.
- Load lanes:
  - Shift right by 8*addr[1:0], take 8, 16 or 32 bits.
  - Sign-extend unless unsigned=1. Unsigned word is identical to word.
  - dBe_out for loads is the same mask as for stores.
- dAck_in outside REQ is ignored.
- Reset mid-access: asynchronous return to IDLE with dReq_out = 0. A pending ack is dropped.
- Load-use back-pressure: a memory op occupies 3 cycles minimum (IDLE→REQ→DONE) with 1-cycle ack.

Test Plan:
- Non-memory: memOp=0, wdOp=0b001011, exResult=0x1234 → next cycle wdOp_out=0b001011, wbData_out=0x1234, stall_out=0, dReq_out=0.
- Signed byte load: addr 0x103, size=00, unsigned=0; ack 2 cycles after dReq_out with rdata=0x80FF_0000 → dBe_out=1000; stall_out high 3 cycles; DONE gives wbData_out=0xFFFF_FF80.
- Unsigned half load: addr 0x202, rdata=0xBEEF_1234 → wbData_out=0x0000_BEEF. Signed variant → 0xFFFF_BEEF.
- Byte store: addr 0x301, rs2=0xAABBCCDD → dWe_out=1, dBe_out=0010, dWdata_out=0xDDDDDDDD, dAddr_out=0x301. Hold with no ack for 10 cycles → bus outputs stable, stall_out=1.
- Misaligned word: addr 0x402, size=10 → misalign_out pulses 1 cycle, dReq_out stays 0, wdOp_out=0, stall_out=0.
- Reset asserted in REQ → dReq_out=0 and state IDLE immediately. After release, a non-memory op passes with 1-cycle latency; a stray dAck_in is ignored.
